// File: rtl/pwm_shadow_bank.sv
// pwm_shadow_bank: per-channel scratch registers committed to live PWM compare/fraction
// outputs either immediately or at the next period boundary, with timeout and error flags.
module pwm_shadow_bank #(
  parameter int NCH = 2,
  parameter int WIDTH = 19,
  parameter int DSBITS = 8,
  parameter int REGBITS = 4,
  parameter logic [WIDTH-1:0] CMP_RESET = 19'h50005,
  parameter logic [DSBITS-1:0] DS_RESET = 8'h12,
  parameter int TIMEOUT = 2 ** 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REGBITS-1:0]      regAddr,
  input  logic [7:0]              regData,
  input  logic                    regDataValid,
  input  logic                    period_start,
  output logic [NCH*WIDTH-1:0]    cmp_out,
  output logic [NCH*DSBITS-1:0]   ds_out,
  output logic [NCH-1:0]          dirty,
  output logic                    pending,
  output logic                    applied,
  output logic                    err_drop,
  output logic                    err_timeout
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [REGBITS-1:0] CTRL_A = REGBITS'(4 * NCH);
  localparam logic [REGBITS-1:0] MODE_A = REGBITS'(4 * NCH + 1);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_n;
  logic [NCH*WIDTH-1:0] sc_cmp;
  logic [NCH*DSBITS-1:0] sc_ds;
  logic [WIDTH-1:0] mrg [NCH];
  logic [NCH-1:0] mask, mask_n, app, hit, blk, wen, drop, ctrl_d;
  logic [CW-1:0] cnt;
  logic [REGBITS-3:0] ch;
  logic [1:0] off;
  logic sync_mode, is_ch, is_ctrl, is_mode, off_ok, tmo;
  assign ch = regAddr[REGBITS-1:2];
  assign off = regAddr[1:0];
  assign ctrl_d = regData[NCH-1:0];
  assign is_ch = regDataValid && regAddr < CTRL_A;
  assign is_ctrl = regDataValid && regAddr == CTRL_A;
  assign is_mode = regDataValid && regAddr == MODE_A;
  assign off_ok = off != 2'd2 || WIDTH > 16;
  assign pending = state == PENDING;
  // masked channels are frozen while a sync commit waits
  assign blk = pending ? mask : '0;
  assign wen = hit & {NCH{off_ok}} & ~blk;
  assign drop = hit & blk;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [23:0] ext;
    assign ext = 24'(sc_cmp[k*WIDTH +: WIDTH]);
    assign mrg[k] = WIDTH'(off == 2'd0 ? {ext[23:8], regData} :
                           off == 2'd1 ? {ext[23:16], regData, ext[7:0]} :
                                         {regData, ext[15:0]});
    assign hit[k] = is_ch && ch == (REGBITS-2)'(k);
  end
  always_comb begin
    state_n = state;
    mask_n = mask;
    app = '0;
    tmo = 1'b0;
    if (state == IDLE) begin
      if (is_ctrl && ctrl_d != '0) begin
        if (!sync_mode || period_start) app = ctrl_d;
        else begin
          state_n = PENDING;
          mask_n = ctrl_d;
        end
      end
    end else begin
      mask_n = is_ctrl ? mask | ctrl_d : mask;
      if (period_start || cnt == CW'(TIMEOUT - 1)) begin
        app = mask_n;
        mask_n = '0;
        state_n = IDLE;
        tmo = !period_start;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_cmp <= {NCH{CMP_RESET}};
      cmp_out <= {NCH{CMP_RESET}};
      sc_ds <= {NCH{DS_RESET}};
      ds_out <= {NCH{DS_RESET}};
      dirty <= '0;
      applied <= 1'b0;
      err_drop <= 1'b0;
      err_timeout <= 1'b0;
      mask <= '0;
      sync_mode <= 1'b0;
      cnt <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wen[k] && off == 2'd3) sc_ds[k*DSBITS +: DSBITS] <= regData[DSBITS-1:0];
        if (wen[k] && off != 2'd3) sc_cmp[k*WIDTH +: WIDTH] <= mrg[k];
        if (app[k]) cmp_out[k*WIDTH +: WIDTH] <= sc_cmp[k*WIDTH +: WIDTH];
        if (app[k]) ds_out[k*DSBITS +: DSBITS] <= sc_ds[k*DSBITS +: DSBITS];
      end
      dirty <= (dirty & ~app) | wen;
      applied <= |app;
      err_drop <= is_mode ? 1'b0 : err_drop | (|drop);
      err_timeout <= is_mode ? 1'b0 : err_timeout | tmo;
      sync_mode <= is_mode ? regData[0] : sync_mode;
      mask <= mask_n;
      cnt <= (state == PENDING && state_n == PENDING) ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_pwm_shadow_bank.sv
// tb_pwm_shadow_bank: directed checks of scratch writes, immediate/sync commits, drops and timeout.
module tb_pwm_shadow_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] regAddr = '0;
  logic [7:0] regData = '0;
  logic regDataValid = 1'b0;
  logic period_start = 1'b0;
  logic [37:0] cmp_out;
  logic [15:0] ds_out;
  logic [1:0] dirty;
  logic pending, applied, err_drop, err_timeout;
  int checks = 0;
  int errors = 0;

  pwm_shadow_bank #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .regAddr(regAddr), .regData(regData),
    .regDataValid(regDataValid), .period_start(period_start), .cmp_out(cmp_out),
    .ds_out(ds_out), .dirty(dirty), .pending(pending), .applied(applied),
    .err_drop(err_drop), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic ps);
    @(negedge clk);
    regAddr = a;
    regData = d;
    regDataValid = 1'b1;
    period_start = ps;
    @(negedge clk);
    regDataValid = 1'b0;
    period_start = 1'b0;
  endtask

  task automatic pulse_ps();
    @(negedge clk);
    period_start = 1'b1;
    @(negedge clk);
    period_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmp_out !== {2{19'h50005}}) begin errors++; $display("FAIL reset_cmp got %h want %h", cmp_out, {2{19'h50005}}); end
    checks++; if (ds_out !== 16'h1212) begin errors++; $display("FAIL reset_ds got %h want 1212", ds_out); end
    checks++; if ({dirty, pending, applied, err_drop, err_timeout} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {dirty, pending, applied, err_drop, err_timeout}); end
  endtask

  task automatic test_immediate();
    wr(4'd9, 8'h00, 1'b0);
    wr(4'd4, 8'h34, 1'b0);
    wr(4'd5, 8'h12, 1'b0);
    wr(4'd6, 8'h03, 1'b0);
    wr(4'd7, 8'h55, 1'b0);
    checks++; if (dirty !== 2'b10) begin errors++; $display("FAIL imm_dirty_set got %b want 10", dirty); end
    checks++; if (cmp_out[37:19] !== 19'h50005) begin errors++; $display("FAIL imm_before got %h want 50005", cmp_out[37:19]); end
    wr(4'd8, 8'h02, 1'b0);
    checks++; if (cmp_out[37:19] !== 19'h31234) begin errors++; $display("FAIL imm_cmp1 got %h want 31234", cmp_out[37:19]); end
    checks++; if (cmp_out[18:0] !== 19'h50005) begin errors++; $display("FAIL imm_cmp0 got %h want 50005", cmp_out[18:0]); end
    checks++; if (ds_out !== 16'h5512) begin errors++; $display("FAIL imm_ds got %h want 5512", ds_out); end
    checks++; if (applied !== 1'b1) begin errors++; $display("FAIL imm_applied got %b want 1", applied); end
    checks++; if (dirty !== 2'b00) begin errors++; $display("FAIL imm_dirty_clr got %b want 00", dirty); end
    @(negedge clk);
    checks++; if (applied !== 1'b0) begin errors++; $display("FAIL imm_applied_pulse got %b want 0", applied); end
  endtask

  task automatic test_idle_noop();
    wr(4'd8, 8'h00, 1'b0);
    checks++; if ({applied, pending} !== 2'b00) begin errors++; $display("FAIL zero_mask got %b want 00", {applied, pending}); end
    pulse_ps();
    checks++; if ({applied, pending} !== 2'b00) begin errors++; $display("FAIL idle_ps got %b want 00", {applied, pending}); end
  endtask

  task automatic test_sync();
    wr(4'd9, 8'h01, 1'b0);
    wr(4'd0, 8'hAA, 1'b0);
    wr(4'd8, 8'h01, 1'b0);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL sync_pending got %b want 1", pending); end
    checks++; if ({applied, cmp_out[18:0]} !== {1'b0, 19'h50005}) begin errors++; $display("FAIL sync_hold got %b/%h want 0/50005", applied, cmp_out[18:0]); end
    repeat (8) @(negedge clk);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL sync_wait got %b want 1", pending); end
    pulse_ps();
    checks++; if (cmp_out[18:0] !== 19'h500AA) begin errors++; $display("FAIL sync_cmp0 got %h want 500aa", cmp_out[18:0]); end
    checks++; if ({pending, applied, err_timeout, dirty} !== 5'b01000) begin errors++; $display("FAIL sync_flags got %b want 01000", {pending, applied, err_timeout, dirty}); end
  endtask

  task automatic test_drop();
    wr(4'd8, 8'h01, 1'b0);
    wr(4'd1, 8'h77, 1'b0);
    checks++; if ({err_drop, dirty} !== 3'b100) begin errors++; $display("FAIL drop_flag got %b want 100", {err_drop, dirty}); end
    wr(4'd4, 8'h99, 1'b0);
    checks++; if (dirty !== 2'b10) begin errors++; $display("FAIL drop_other got %b want 10", dirty); end
    wr(4'd8, 8'h02, 1'b0);
    checks++; if (cmp_out !== {19'h31234, 19'h500AA}) begin errors++; $display("FAIL drop_hold got %h want %h", cmp_out, {19'h31234, 19'h500AA}); end
    pulse_ps();
    checks++; if (cmp_out !== {19'h31299, 19'h500AA}) begin errors++; $display("FAIL drop_apply got %h want %h", cmp_out, {19'h31299, 19'h500AA}); end
    checks++; if ({pending, applied, dirty} !== 4'b0100) begin errors++; $display("FAIL drop_flags got %b want 0100", {pending, applied, dirty}); end
  endtask

  task automatic test_boundary();
    wr(4'd9, 8'h01, 1'b0);
    checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL mode_clr_drop got %b want 0", err_drop); end
    wr(4'd4, 8'h01, 1'b0);
    wr(4'd8, 8'h02, 1'b1);
    checks++; if ({pending, applied, cmp_out[37:19]} !== {2'b01, 19'h31201}) begin errors++; $display("FAIL boundary got %b%b/%h want 01/31201", pending, applied, cmp_out[37:19]); end
  endtask

  task automatic test_timeout();
    wr(4'd0, 8'h55, 1'b0);
    wr(4'd8, 8'h01, 1'b0);
    repeat (15) @(negedge clk);
    checks++; if ({pending, applied, err_timeout} !== 3'b100) begin errors++; $display("FAIL tmo_early got %b want 100", {pending, applied, err_timeout}); end
    @(negedge clk);
    checks++; if ({pending, applied, err_timeout} !== 3'b011) begin errors++; $display("FAIL tmo_fire got %b want 011", {pending, applied, err_timeout}); end
    checks++; if (cmp_out[18:0] !== 19'h50055) begin errors++; $display("FAIL tmo_cmp got %h want 50055", cmp_out[18:0]); end
    wr(4'd9, 8'h01, 1'b0);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", err_timeout); end
  endtask

  task automatic test_reset_pending();
    wr(4'd0, 8'h11, 1'b0);
    wr(4'd8, 8'h01, 1'b0);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rp_pending got %b want 1", pending); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({pending, dirty, cmp_out, ds_out} !== {3'b000, {2{19'h50005}}, 16'h1212}) begin errors++; $display("FAIL rp_reset got %b%b/%h/%h want reset", pending, dirty, cmp_out, ds_out); end
    pulse_ps();
    checks++; if ({applied, cmp_out} !== {1'b0, {2{19'h50005}}}) begin errors++; $display("FAIL rp_ps got %b/%h want 0/reset", applied, cmp_out); end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_idle_noop();
    test_sync();
    test_drop();
    test_boundary();
    test_timeout();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_shadow_bank.md
# pwm_shadow_bank

Multi-channel shadow register bank between the I2C register interface and the PWM cores. Byte writes from the I2C register port land in per-channel scratch registers. A commit command copies them atomically into the live compare/delta-sigma outputs for a selected set of channels, either immediately or at the next PWM period boundary. A timeout forces the copy if no boundary arrives. This generalises the single-channel, immediate-only scratch/commit scheme to NCH channels with a synchronous apply mode and error reporting.

## Interface
- NCH, 2: channel count, 1..8.
- WIDTH, 19: compare width, 9..24.
- DSBITS, 8: delta-sigma fraction width, 1..8.
- REGBITS, 4: register address width; 2^REGBITS ≥ 4·NCH+2.
- CMP_RESET, 19'h50005: reset value of every channel's compare, scratch and live.
- DS_RESET, 8'h12: reset value of every channel's fraction, scratch and live.
- TIMEOUT, 2^20: cycles in PENDING before a forced apply.
- clk  in  1  single clock, same domain as the I2C register interface and the PWM core SCLK.
- rst_n  in  1  asynchronous, active-low reset.
- regAddr  in  REGBITS  byte register address.
- regData  in  8  write data.
- regDataValid  in  1  one-cycle write strobe.
- period_start  in  1  one-cycle pulse from the PWM core at the period wrap.
- cmp_out  out  NCH·WIDTH  live compares; channel k occupies [k·WIDTH +: WIDTH].
- ds_out  out  NCH·DSBITS  live fractions, packed the same way.
- dirty  out  NCH  scratch differs from live since last apply (write-tracked, not compared).
- pending  out  1  a synchronous commit is waiting.
- applied  out  1  one-cycle pulse when live outputs change.
- err_drop  out  1  sticky: a write was dropped.
- err_timeout  out  1  sticky: an apply was forced by timeout.

## Operation
- Address map: channel k, offsets 4k+0/1/2 hold compare bytes [7:0]/[15:8]/[WIDTH-1:16]. Offset 4k+3 holds the fraction, low DSBITS bits. Bits beyond WIDTH are dropped. An offset-2 write when WIDTH≤16 is ignored.
- CTRL = 4·NCH writes the commit mask, regData[NCH-1:0]; upper bits are ignored. MODE = 4·NCH+1: bit0 is sync_mode (reset 0). Any MODE write clears err_drop and err_timeout.
- Other addresses are ignored without error.
- A scratch write sets dirty[k].
- State machine IDLE/PENDING; the mask register is held internally.
- IDLE, CTRL write, sync_mode=0: copy scratch→live for masked channels, clear their dirty bits, pulse applied. Stay in IDLE.
- IDLE, CTRL write, sync_mode=1: mask←data, go to PENDING, clear the timeout counter.
- IDLE, mask=0 write in either mode: no-op, no applied pulse.
- PENDING, period_start: apply masked channels, clear mask, go to IDLE.
- PENDING, counter reaches TIMEOUT-1: apply the same way, set err_timeout, go to IDLE.
- PENDING, CTRL write: mask |= data. A simultaneous period_start applies the OR-ed mask.
- PENDING, scratch write to a masked channel: dropped, err_drop set. Writes to unmasked channels proceed normally.
- CTRL write and period_start in the same IDLE cycle with sync_mode=1: apply at that boundary, with the same timing as the immediate case.
- sync_mode changes while in PENDING take effect only for the next commit.
- Reset: all scratch and live set to CMP_RESET/DS_RESET. dirty, pending, applied, err_drop, err_timeout, mask, sync_mode and counter all 0. State IDLE.
- Reset mid-PENDING discards the commit.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- Scratch write on strobe cycle N: dirty visible at N+1.
- Immediate commit on strobe cycle N: cmp_out, ds_out and dirty update at N+1. applied is high for exactly cycle N+1.
- Sync commit on strobe cycle N: pending is high from N+1. A period_start on cycle M>N updates outputs at M+1, pulses applied at M+1, and drops pending at M+1.
- Timeout: the forced apply occurs TIMEOUT cycles after pending rises.
- A period_start while in IDLE has no effect.

## Test plan
- Reset, then read outputs → cmp_out = {19'h50005, 19'h50005}, ds_out = 16'h1212, all flags 0.
- sync_mode=0. Write addresses 4,5,6,7 with 0x34, 0x12, 0x03, 0x55, then CTRL=0x02 → channel 1 cmp=19'h31234, ds=0x55, and applied at strobe+1. Channel 0 unchanged. dirty goes 2'b10→2'b00.
- sync_mode=1. Write address 0=0xAA, then CTRL=0x01 → pending=1 and outputs unchanged. period_start 10 cycles later → channel 0 cmp low byte 0xAA on the next cycle, pending=0.
- In PENDING with mask=0x01: write address 1 → err_drop=1 and scratch unchanged. Write address 4 → accepted. CTRL=0x02 then period_start → both channels apply together.
- TIMEOUT=16, sync commit, no period_start → apply and err_timeout=1 exactly 16 cycles after pending rises. A MODE write clears err_timeout.
- Assert rst_n mid-PENDING → pending=0 and outputs return to reset values. A later period_start has no effect.
